multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_WAIT_EN, default 1, meaning 1 = memory states wait for mem_ready, 0 = mem_ready ignored and treated as 1.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction opcode from instruction register bits [31:26].
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 AluOp  output  2  to ALU decoder: 00 add, 01 subtract, 10 use funct field.
REQ-008 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-009 ALUSrcB  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-010 IorD, RegDst, MemtoReg  output  1 each  address, destination and writeback-source multiplexer selects.
REQ-011 PCSrc  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-012 IRWrite, MemRead, MemWrite, RegWrite, PCWrite, Branch  output  1 each  write and read enables.
REQ-013 pc_en  output  1  PCWrite OR (Branch AND zero).
REQ-014 illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-015 state_o  output  4  current state encoding, for debug.

Function
REQ-016 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH on the next edge.
REQ-017 Outputs are Moore-decoded from state, except the mem_ready gating in REQ-018; every signal not listed for a state is 0.
REQ-018 FETCH: MemRead=1, ALUSrcB=01, AluOp=00, PCSrc=00, IorD=0; IRWrite=PCWrite=mem_ready; next state is DECODE if mem_ready, otherwise FETCH (hold).
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=11, AluOp=00; next state by opcode:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXEC
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other opcode -> FETCH, with illegal_op=1 in this cycle
REQ-020 MEMADR: ALUSrcA=1, ALUSrcB=10, AluOp=00; next state MEMRD for lw, MEMWR for sw (opcode is held stable by IR).
REQ-021 MEMRD: MemRead=1, IorD=1; next state MEMWB if mem_ready, otherwise hold.
REQ-022 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next state FETCH.
REQ-023 MEMWR: MemWrite=1, IorD=1; next state FETCH if mem_ready, otherwise hold with MemWrite still 1.
REQ-024 EXEC: ALUSrcA=1, ALUSrcB=00, AluOp=10; next state ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, AluOp=01, PCSrc=01, Branch=1; next state FETCH.
REQ-026 ADDIEX: ALUSrcA=1, ALUSrcB=10, AluOp=00; next state ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
REQ-027 JUMP: PCWrite=1, PCSrc=10; next state FETCH.
REQ-028 Instruction latency, with mem_ready high: lw 5 cycles; R-type, sw and addi 4 cycles; beq and j 3 cycles; each cycle of mem_ready low adds one cycle.

Reset
REQ-029 While rst_n=0: state=FETCH immediately, and every enable (IRWrite, MemRead, MemWrite, RegWrite, PCWrite, Branch, pc_en, illegal_op) is forced to 0 regardless of mem_ready.
REQ-030 Reset asserted in any state aborts the instruction with no further writes; the first edge after release evaluates FETCH.

Structure
REQ-031 Opcode constants, state encodings and AluOp codes SHALL live in a shared MIPS package that both the datapath and the ALU decoder import.
REQ-032 The block is a single module with no sub-modules: a state register plus combinational next-state and output logic.

Verification
REQ-033 lw (100011), mem_ready=1 -> state_o sequence 0,1,2,3,4,0; AluOp=00 in MEMADR; RegWrite=1 and MemtoReg=1 only in MEMWB.
REQ-034 R-type (000000) -> sequence 0,1,6,7,0; AluOp=10 in EXEC; RegWrite=1 and RegDst=1 in ALUWB.
REQ-035 beq with zero=1 -> pc_en=1 in BRANCH with AluOp=01 and PCSrc=01; with zero=0 -> pc_en=0 throughout BRANCH.
REQ-036 mem_ready low for 3 cycles in FETCH -> state holds at 0 and IRWrite=PCWrite=0 for those cycles; DECODE follows the first cycle with mem_ready high.
REQ-037 Opcode 111111 -> illegal_op pulses for one cycle in DECODE, then FETCH; no write enable is asserted.
REQ-038 rst_n driven low mid-MEMWB -> state_o=0 and RegWrite=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared MIPS control definitions: opcodes, FSM state encodings and the AluOp,
// ALUSrcB and PCSrc select codes. Imported by the control FSM, and meant to be
// imported by the datapath and the ALU decoder as well, so that all of them use
// the same encodings.
package multicycle_control_pkg;

  // Instruction opcodes, taken from IR bits [31:26].
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // AluOp codes passed to the ALU decoder.
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // ALUSrcB selects.
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PCSrc selects.
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // Debug-visible state encodings. Codes 12-15 are not used.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   opcode              IR[31:26]
//   zero                ALU zero flag (used for beq via pc_en)
//   mem_ready           memory access completes this cycle
//   AluOp, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg  datapath selects
//   IRWrite, MemRead, MemWrite, RegWrite, PCWrite, Branch  enables
//   pc_en               PCWrite | (Branch & zero)
//   illegal_op          one-cycle pulse when DECODE sees an unsupported opcode
//   state_o             current state, for debug
// Outputs are decoded from the state register. The only input dependences are
// the mem_ready gating of IRWrite/PCWrite in FETCH, the illegal_op flag in
// DECODE and zero in pc_en. While reset is asserted every enable is forced low.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] AluOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  logic   mem_rdy;

  // Raw enables before reset gating.
  logic ir_write_raw, mem_read_raw, mem_write_raw, reg_write_raw;
  logic pc_write_raw, branch_raw, illegal_raw;

  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = StFetch;
    AluOp         = AluAdd;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SrcBReg;
    PCSrc         = PcSrcAlu;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    pc_write_raw  = 1'b0;
    branch_raw    = 1'b0;
    illegal_raw   = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read_raw = 1'b1;
        ALUSrcB      = SrcBFour;
        // IR and PC only capture once the instruction word is actually back.
        ir_write_raw = mem_rdy;
        pc_write_raw = mem_rdy;
        state_d      = mem_rdy ? StDecode : StFetch;
      end
      StDecode: begin
        // Precompute the branch target while the register file is read.
        ALUSrcB = SrcBImmSh;
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d     = StFetch;
            illegal_raw = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        // Only lw and sw reach here; IR holds the opcode stable.
        state_d = (opcode == OpLw) ? StMemRd :
                  (opcode == OpSw) ? StMemWr : StFetch;
      end
      StMemRd: begin
        mem_read_raw = 1'b1;
        IorD         = 1'b1;
        state_d      = mem_rdy ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        state_d       = StFetch;
      end
      StMemWr: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        state_d       = mem_rdy ? StFetch : StMemWr;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        AluOp   = AluFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        AluOp      = AluSub;
        PCSrc      = PcSrcAluOut;
        branch_raw = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SrcBImm;
        state_d = StAddiWb;
      end
      StAddiWb: begin
        reg_write_raw = 1'b1;
        state_d       = StFetch;
      end
      StJump: begin
        pc_write_raw = 1'b1;
        PCSrc        = PcSrcJump;
        state_d      = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset must silence every enable immediately, not at the next edge.
  assign IRWrite    = rst_n & ir_write_raw;
  assign MemRead    = rst_n & mem_read_raw;
  assign MemWrite   = rst_n & mem_write_raw;
  assign RegWrite   = rst_n & reg_write_raw;
  assign PCWrite    = rst_n & pc_write_raw;
  assign Branch     = rst_n & branch_raw;
  assign illegal_op = rst_n & illegal_raw;
  assign pc_en      = PCWrite | (Branch & zero);
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each scenario queues per-cycle
// records (inputs plus expected state/illegal flag), then drains the queue one
// clock at a time comparing the DUT against a hand-written per-state table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] AluOp, ALUSrcB, PCSrc;
  logic       ALUSrcA, IorD, RegDst, MemtoReg;
  logic       IRWrite, MemRead, MemWrite, RegWrite, PCWrite, Branch;
  logic       pc_en, illegal_op;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .AluOp      (AluOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .IorD       (IorD),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc),
    .IRWrite    (IRWrite),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // {AluOp, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
  //  IRWrite, MemRead, MemWrite, RegWrite, PCWrite, Branch}
  logic [15:0] obs;
  assign obs = {AluOp, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
                IRWrite, MemRead, MemWrite, RegWrite, PCWrite, Branch};

  logic [15:0] tab [16];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BADOP = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       z;
    logic [5:0] op;
    logic       ill;
  } rec_t;

  rec_t sb[$];

  function automatic void push(input logic [3:0] st, input logic mr, input logic z,
                               input logic [5:0] op, input logic ill);
    rec_t r;
    r.st = st; r.mr = mr; r.z = z; r.op = op; r.ill = ill;
    sb.push_back(r);
  endfunction

  // Expected output vector: FETCH additionally raises IRWrite and PCWrite on mem_ready.
  function automatic logic [15:0] exp_vec(input logic [3:0] st, input logic mr);
    logic [15:0] v;
    v = tab[st];
    if (st == 4'd0 && mr) v = v | 16'h0022;
    return v;
  endfunction

  task automatic test_reset();
    mem_ready = 1'b1; zero = 1'b1; opcode = LW;
    rst_n = 1'b0;
    #3;
    total += 4;
    if (state_o !== 4'd0) begin bad++; $display("FAIL reset state: got %0d want 0", state_o); end
    if (IRWrite !== 1'b0 || MemRead !== 1'b0) begin
      bad++; $display("FAIL reset fetch enables: got IRW=%b MR=%b want 0 0", IRWrite, MemRead);
    end
    if (PCWrite !== 1'b0 || pc_en !== 1'b0) begin
      bad++; $display("FAIL reset pc enables: got PCW=%b pc_en=%b want 0 0", PCWrite, pc_en);
    end
    if ({MemWrite, RegWrite, Branch, illegal_op} !== 4'b0) begin
      bad++; $display("FAIL reset other enables: got %b want 0000",
                      {MemWrite, RegWrite, Branch, illegal_op});
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (state_o !== 4'd0) begin bad++; $display("FAIL reset hold state: got %0d want 0", state_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    rec_t r;
    logic [15:0] ev;
    push(0, 1, 0, LW, 0); push(1, 1, 0, LW, 0); push(2, 1, 0, LW, 0);
    push(3, 1, 0, LW, 0); push(4, 1, 0, LW, 0); push(0, 0, 0, LW, 0);
    // lw with a two-cycle memory stall in MEMRD
    push(0, 1, 0, LW, 0); push(1, 1, 0, LW, 0); push(2, 1, 0, LW, 0);
    push(3, 0, 0, LW, 0); push(3, 0, 0, LW, 0); push(3, 1, 0, LW, 0);
    push(4, 1, 0, LW, 0); push(0, 0, 0, LW, 0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr; zero = r.z; opcode = r.op;
      #1;
      ev = exp_vec(r.st, r.mr);
      total += 4;
      if (state_o !== r.st) begin bad++; $display("FAIL lw state: got %0d want %0d", state_o, r.st); end
      if (obs !== ev) begin bad++; $display("FAIL lw outs st%0d: got %b want %b", r.st, obs, ev); end
      if (pc_en !== (ev[1] | (ev[0] & r.z))) begin bad++; $display("FAIL lw pc_en st%0d: got %b", r.st, pc_en); end
      if (illegal_op !== r.ill) begin bad++; $display("FAIL lw illegal st%0d: got %b want %b", r.st, illegal_op, r.ill); end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype_sw();
    rec_t r;
    logic [15:0] ev;
    push(0, 1, 0, RT, 0); push(1, 1, 0, RT, 0); push(6, 1, 0, RT, 0);
    push(7, 1, 0, RT, 0); push(0, 0, 0, RT, 0);
    // sw with one stalled MEMWR cycle
    push(0, 1, 0, SW, 0); push(1, 1, 0, SW, 0); push(2, 1, 0, SW, 0);
    push(5, 0, 0, SW, 0); push(5, 1, 0, SW, 0); push(0, 0, 0, SW, 0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr; zero = r.z; opcode = r.op;
      #1;
      ev = exp_vec(r.st, r.mr);
      total += 4;
      if (state_o !== r.st) begin bad++; $display("FAIL rt/sw state: got %0d want %0d", state_o, r.st); end
      if (obs !== ev) begin bad++; $display("FAIL rt/sw outs st%0d: got %b want %b", r.st, obs, ev); end
      if (pc_en !== (ev[1] | (ev[0] & r.z))) begin bad++; $display("FAIL rt/sw pc_en st%0d: got %b", r.st, pc_en); end
      if (illegal_op !== r.ill) begin bad++; $display("FAIL rt/sw illegal st%0d: got %b want %b", r.st, illegal_op, r.ill); end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    rec_t r;
    logic [15:0] ev;
    push(0, 1, 1, BEQ, 0); push(1, 1, 1, BEQ, 0); push(8, 1, 1, BEQ, 0); push(0, 0, 1, BEQ, 0);
    push(0, 1, 0, BEQ, 0); push(1, 1, 0, BEQ, 0); push(8, 1, 0, BEQ, 0); push(0, 0, 0, BEQ, 0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr; zero = r.z; opcode = r.op;
      #1;
      ev = exp_vec(r.st, r.mr);
      total += 4;
      if (state_o !== r.st) begin bad++; $display("FAIL beq state: got %0d want %0d", state_o, r.st); end
      if (obs !== ev) begin bad++; $display("FAIL beq outs st%0d: got %b want %b", r.st, obs, ev); end
      if (pc_en !== (ev[1] | (ev[0] & r.z))) begin
        bad++; $display("FAIL beq pc_en st%0d z=%b: got %b want %b", r.st, r.z, pc_en, ev[1] | (ev[0] & r.z));
      end
      if (illegal_op !== r.ill) begin bad++; $display("FAIL beq illegal st%0d: got %b want %b", r.st, illegal_op, r.ill); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    logic [15:0] ev;
    // j directly followed by addi, with FETCH ready both times
    push(0, 1, 0, JMP, 0); push(1, 1, 0, JMP, 0); push(11, 1, 0, JMP, 0);
    push(0, 1, 0, ADDI, 0); push(1, 1, 0, ADDI, 0); push(9, 1, 0, ADDI, 0);
    push(10, 1, 0, ADDI, 0); push(0, 0, 0, ADDI, 0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr; zero = r.z; opcode = r.op;
      #1;
      ev = exp_vec(r.st, r.mr);
      total += 4;
      if (state_o !== r.st) begin bad++; $display("FAIL b2b state: got %0d want %0d", state_o, r.st); end
      if (obs !== ev) begin bad++; $display("FAIL b2b outs st%0d: got %b want %b", r.st, obs, ev); end
      if (pc_en !== (ev[1] | (ev[0] & r.z))) begin bad++; $display("FAIL b2b pc_en st%0d: got %b", r.st, pc_en); end
      if (illegal_op !== r.ill) begin bad++; $display("FAIL b2b illegal st%0d: got %b want %b", r.st, illegal_op, r.ill); end
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_wait_illegal();
    rec_t r;
    logic [15:0] ev;
    push(0, 0, 0, RT, 0); push(0, 0, 0, RT, 0); push(0, 0, 0, RT, 0);
    push(0, 1, 0, RT, 0); push(1, 1, 0, RT, 0); push(6, 1, 0, RT, 0);
    push(7, 1, 0, RT, 0);
    // unsupported opcode: pulse in DECODE, then straight back to FETCH
    push(0, 1, 0, BADOP, 0); push(1, 1, 0, BADOP, 1); push(0, 0, 0, BADOP, 0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr; zero = r.z; opcode = r.op;
      #1;
      ev = exp_vec(r.st, r.mr);
      total += 4;
      if (state_o !== r.st) begin bad++; $display("FAIL wait/ill state: got %0d want %0d", state_o, r.st); end
      if (obs !== ev) begin bad++; $display("FAIL wait/ill outs st%0d: got %b want %b", r.st, obs, ev); end
      if (pc_en !== (ev[1] | (ev[0] & r.z))) begin bad++; $display("FAIL wait/ill pc_en st%0d: got %b", r.st, pc_en); end
      if (illegal_op !== r.ill) begin bad++; $display("FAIL wait/ill illegal st%0d: got %b want %b", r.st, illegal_op, r.ill); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    rec_t r;
    logic [15:0] ev;
    push(0, 1, 0, LW, 0); push(1, 1, 0, LW, 0); push(2, 1, 0, LW, 0); push(3, 1, 0, LW, 0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr; zero = r.z; opcode = r.op;
      #1;
      ev = exp_vec(r.st, r.mr);
      total += 2;
      if (state_o !== r.st) begin bad++; $display("FAIL rmid state: got %0d want %0d", state_o, r.st); end
      if (obs !== ev) begin bad++; $display("FAIL rmid outs st%0d: got %b want %b", r.st, obs, ev); end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (state_o !== 4'd4 || RegWrite !== 1'b1) begin
      bad++; $display("FAIL rmid in memwb: got st=%0d RW=%b want 4 1", state_o, RegWrite);
    end
    rst_n = 1'b0;
    #1;
    total += 2;
    if (state_o !== 4'd0 || RegWrite !== 1'b0) begin
      bad++; $display("FAIL rmid async: got st=%0d RW=%b want 0 0", state_o, RegWrite);
    end
    if (MemRead !== 1'b0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      bad++; $display("FAIL rmid gated: got MR=%b IRW=%b PCW=%b want 0 0 0", MemRead, IRWrite, PCWrite);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 1, 0, RT, 0); push(1, 1, 0, RT, 0); push(6, 1, 0, RT, 0);
    push(7, 1, 0, RT, 0); push(0, 0, 0, RT, 0);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr; zero = r.z; opcode = r.op;
      #1;
      ev = exp_vec(r.st, r.mr);
      total += 2;
      if (state_o !== r.st) begin bad++; $display("FAIL rmid after state: got %0d want %0d", state_o, r.st); end
      if (obs !== ev) begin bad++; $display("FAIL rmid after outs st%0d: got %b want %b", r.st, obs, ev); end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tab[i] = 16'h0000;
    tab[0]  = 16'b00_0_01_00_0_0_0_0_1_0_0_0_0;
    tab[1]  = 16'b00_0_11_00_0_0_0_0_0_0_0_0_0;
    tab[2]  = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0;
    tab[3]  = 16'b00_0_00_00_1_0_0_0_1_0_0_0_0;
    tab[4]  = 16'b00_0_00_00_0_0_1_0_0_0_1_0_0;
    tab[5]  = 16'b00_0_00_00_1_0_0_0_0_1_0_0_0;
    tab[6]  = 16'b10_1_00_00_0_0_0_0_0_0_0_0_0;
    tab[7]  = 16'b00_0_00_00_0_1_0_0_0_0_1_0_0;
    tab[8]  = 16'b01_1_00_01_0_0_0_0_0_0_0_0_1;
    tab[9]  = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0;
    tab[10] = 16'b00_0_00_00_0_0_0_0_0_0_1_0_0;
    tab[11] = 16'b00_0_00_10_0_0_0_0_0_0_0_1_0;

    test_reset();
    test_lw();
    test_rtype_sw();
    test_beq();
    test_back_to_back();
    test_fetch_wait_illegal();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
